// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone master copying a block of words, one read then one write per word.
// Ports: clk/rstn, start_i/src_adr_i/dst_adr_i/len_i in, busy_o/done_o/err_o status, m_* classic WB master.
module wb_dma_copy #(
    parameter int c_DATA_WIDTH = 64,
    parameter int c_LEN_WIDTH  = 16,
    parameter int c_RTY_MAX    = 15
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start_i,
    input  logic [31:0]               src_adr_i,
    input  logic [31:0]               dst_adr_i,
    input  logic [c_LEN_WIDTH-1:0]    len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [31:0]               m_adr_o,
    output logic [c_DATA_WIDTH-1:0]   m_dat_o,
    input  logic [c_DATA_WIDTH-1:0]   m_dat_i,
    output logic [c_DATA_WIDTH/8-1:0] m_sel_o,
    output logic                      m_we_o,
    output logic                      m_cyc_o,
    output logic                      m_stb_o,
    output logic [2:0]                m_cti_o,
    input  logic                      m_ack_i,
    input  logic                      m_err_i,
    input  logic                      m_rty_i
);

    localparam int          c_SEL_WIDTH = c_DATA_WIDTH / 8;
    localparam int          c_RTY_WIDTH = $clog2(c_RTY_MAX + 2);
    localparam logic [31:0] c_STEP      = 32'(c_SEL_WIDTH);
    localparam logic [c_RTY_WIDTH-1:0] c_RTY_LIMIT = c_RTY_WIDTH'(c_RTY_MAX);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_SETUP = 3'd1;
    localparam logic [2:0] S_RD_CYC   = 3'd2;
    localparam logic [2:0] S_WR_SETUP = 3'd3;
    localparam logic [2:0] S_WR_CYC   = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]               r_state;
    logic [31:0]              r_src_ptr;
    logic [31:0]              r_dst_ptr;
    logic [c_LEN_WIDTH-1:0]   r_remaining;
    logic [c_RTY_WIDTH-1:0]   r_rty_cnt;
    logic [31:0]              r_adr;
    // Write-data register doubles as the read buffer: the read ack loads it
    // directly, so it is already valid during WR_SETUP.
    logic [c_DATA_WIDTH-1:0]  r_dat;
    logic [c_SEL_WIDTH-1:0]   r_sel;
    logic                     r_we;
    logic                     r_cyc;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;

    logic [c_RTY_WIDTH-1:0]   w_rty_next;
    logic                     w_rty_abort;
    logic                     w_last;
    logic [31:0]              w_src_next;
    logic [31:0]              w_dst_next;
    logic                     w_is_rd;

    assign w_rty_next  = r_rty_cnt + c_RTY_WIDTH'(1);
    assign w_rty_abort = (w_rty_next > c_RTY_LIMIT);
    assign w_last      = (r_remaining == c_LEN_WIDTH'(1));
    assign w_src_next  = r_src_ptr + c_STEP;
    assign w_dst_next  = r_dst_ptr + c_STEP;
    assign w_is_rd     = (r_state == S_RD_CYC);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_rty_cnt   <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_src_ptr   <= src_adr_i;
                        r_dst_ptr   <= dst_adr_i;
                        r_remaining <= len_i;
                        r_rty_cnt   <= '0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        if (len_i == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_adr   <= src_adr_i;
                            r_we    <= 1'b0;
                            r_sel   <= '1;
                            r_state <= S_RD_SETUP;
                        end
                    end
                end
                S_RD_SETUP: begin
                    r_cyc   <= 1'b1;
                    r_state <= S_RD_CYC;
                end
                S_WR_SETUP: begin
                    r_cyc   <= 1'b1;
                    r_state <= S_WR_CYC;
                end
                S_RD_CYC, S_WR_CYC: begin
                    if (m_err_i) begin
                        r_cyc   <= 1'b0;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (m_ack_i) begin
                        r_cyc     <= 1'b0;
                        r_rty_cnt <= '0;
                        if (w_is_rd) begin
                            r_dat   <= m_dat_i;
                            r_adr   <= r_dst_ptr;
                            r_we    <= 1'b1;
                            r_state <= S_WR_SETUP;
                        end else begin
                            r_src_ptr   <= w_src_next;
                            r_dst_ptr   <= w_dst_next;
                            r_remaining <= r_remaining - c_LEN_WIDTH'(1);
                            if (w_last) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_adr   <= w_src_next;
                                r_we    <= 1'b0;
                                r_sel   <= '1;
                                r_state <= S_RD_SETUP;
                            end
                        end
                    end else if (m_rty_i) begin
                        r_cyc     <= 1'b0;
                        r_rty_cnt <= w_rty_next;
                        if (w_rty_abort) begin
                            r_err   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= w_is_rd ? S_RD_SETUP : S_WR_SETUP;
                        end
                    end
                end
                S_DONE: begin
                    // A zero-length start arrives here with done still low,
                    // spending one busy cycle before the pulse.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign err_o   = r_err;
    assign m_adr_o = r_adr;
    assign m_dat_o = r_dat;
    assign m_sel_o = r_sel;
    assign m_we_o  = r_we;
    assign m_cyc_o = r_cyc;
    assign m_stb_o = r_cyc;
    assign m_cti_o = 3'b000;

endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: randomized and directed copies against a Wishbone slave
// model and a word-level reference of the copy.
module tb_wb_dma_copy;

    localparam int RTY_MAX = 15;

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [63:0] d;
    } acc_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] src_adr_i = '0;
    logic [31:0] dst_adr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, err_o;
    logic [31:0] m_adr_o;
    logic [63:0] m_dat_o;
    logic [63:0] m_dat_i = '0;
    logic [7:0]  m_sel_o;
    logic        m_we_o, m_cyc_o, m_stb_o;
    logic [2:0]  m_cti_o;
    logic        m_ack_i = 1'b0;
    logic        m_err_i = 1'b0;
    logic        m_rty_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_cnt = 0;

    bit [63:0] mem [bit [31:0]];
    acc_t      la[$];

    int s_waits = 0;
    int s_rty_acc = -1;
    int s_rty_n = 0;
    int s_err_acc = -1;
    int s_run = 0;
    int s_seen = 0;
    int s_acc = 0;
    int s_rty_seen = 0;
    int s_rises = 0;
    int s_w = 0;
    logic        p_cyc = 1'b0;
    logic        p_we = 1'b0;
    logic [31:0] p_adr = '0;

    wb_dma_copy dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .src_adr_i (src_adr_i),
        .dst_adr_i (dst_adr_i),
        .len_i     (len_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_sel_o   (m_sel_o),
        .m_we_o    (m_we_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_cti_o   (m_cti_o),
        .m_ack_i   (m_ack_i),
        .m_err_i   (m_err_i),
        .m_rty_i   (m_rty_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Slave: responds at the negedge so the response is seen at the next posedge.
    always @(negedge clk) begin
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_rty_i = 1'b0;
        if (s_run != s_seen) begin
            s_seen = s_run;
            s_acc = 0;
            s_rty_seen = 0;
            s_rises = 0;
            la.delete();
        end
        if (!rstn) begin
            s_w = 0;
            p_cyc = 1'b0;
        end else begin
            if (m_cyc_o && !p_cyc) begin
                s_rises++;
                chk("setup_adr", m_adr_o, p_adr);
                chk("setup_we", m_we_o, p_we);
            end else if (m_cyc_o && p_cyc) begin
                chk("hold_adr", m_adr_o, p_adr);
            end
            if (m_cyc_o && m_stb_o) begin
                if (s_w < s_waits) begin
                    s_w++;
                end else begin
                    s_w = 0;
                    if (s_acc == s_err_acc) begin
                        m_err_i = 1'b1;
                        m_ack_i = 1'b1;
                    end else if (s_acc == s_rty_acc && s_rty_seen < s_rty_n) begin
                        m_rty_i = 1'b1;
                        s_rty_seen++;
                    end else begin
                        m_ack_i = 1'b1;
                        if (m_we_o) begin
                            mem[m_adr_o] = m_dat_o;
                            la.push_back('{m_adr_o, 1'b1, m_dat_o});
                        end else begin
                            m_dat_i = mem.exists(m_adr_o) ? mem[m_adr_o] : 64'h0;
                            la.push_back('{m_adr_o, 1'b0, m_dat_i});
                        end
                        s_acc++;
                    end
                end
            end else begin
                s_w = 0;
            end
            p_cyc = m_cyc_o;
            p_adr = m_adr_o;
            p_we  = m_we_o;
        end
    end

    task automatic run_copy(input string tag, input logic [31:0] src,
                            input logic [31:0] dst, input int len,
                            input int waits, input int rty_acc,
                            input int rty_n, input int err_acc,
                            input bit poke);
        acc_t        ea[$];
        bit [63:0]   mm [bit [31:0]];
        logic [31:0] ra, wa;
        logic [63:0] d;
        int          exp_done, exp_rises, att, done_at, t0, n;
        bit          exp_err, busy_bad, stop;
        d = '0;
        for (int i = 0; i < len; i++) begin
            ra = src + 32'(8 * i);
            if (!mem.exists(ra)) mem[ra] = {$urandom, $urandom};
        end
        mm = mem;
        exp_done = (len == 0) ? 2 : 1;
        exp_rises = 0;
        exp_err = 1'b0;
        stop = 1'b0;
        for (int j = 0; j < 2 * len && !stop; j++) begin
            att = 1;
            if (j == rty_acc) att = (rty_n > RTY_MAX) ? RTY_MAX + 1 : rty_n + 1;
            exp_done += att * (2 + waits);
            exp_rises += att;
            if (j == err_acc || (j == rty_acc && rty_n > RTY_MAX)) begin
                exp_err = 1'b1;
                stop = 1'b1;
            end else begin
                ra = src + 32'(8 * (j / 2));
                wa = dst + 32'(8 * (j / 2));
                if (j % 2 == 0) begin
                    d = mm.exists(ra) ? mm[ra] : 64'h0;
                    ea.push_back('{ra, 1'b0, d});
                end else begin
                    mm[wa] = d;
                    ea.push_back('{wa, 1'b1, d});
                end
            end
        end
        s_waits = waits;
        s_rty_acc = rty_acc;
        s_rty_n = rty_n;
        s_err_acc = err_acc;
        s_run++;
        src_adr_i = src;
        dst_adr_i = dst;
        len_i = 16'(len);
        start_i = 1'b1;
        t0 = cyc_cnt;
        done_at = -1;
        busy_bad = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            n = cyc_cnt - t0;
            if (n == 1) chk({tag, ".err_clr"}, err_o, 1'b0);
            if (done_o) begin
                done_at = n;
                break;
            end
            if (!busy_o) busy_bad = 1'b1;
        end
        if (done_at < 0) begin
            chk({tag, ".done_seen"}, done_o, 1'b1);
        end else begin
            chk({tag, ".done_cyc"}, 64'(done_at), 64'(exp_done));
            chk({tag, ".busy_at_done"}, busy_o, 1'b0);
            chk({tag, ".err"}, err_o, exp_err);
        end
        chk({tag, ".busy_gap"}, busy_bad, 1'b0);
        if (poke) begin
            len_i = 16'd1;
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
            chk({tag, ".start_at_done"}, busy_o, 1'b0);
        end else begin
            @(negedge clk);
            chk({tag, ".done_pulse"}, done_o, 1'b0);
        end
        chk({tag, ".nacc"}, 64'(la.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < la.size(); i++) begin
            chk({tag, ".adr"}, la[i].a, ea[i].a);
            chk({tag, ".we"}, la[i].w, ea[i].w);
            chk({tag, ".dat"}, la[i].d, ea[i].d);
        end
        chk({tag, ".strobes"}, 64'(s_rises), 64'(exp_rises));
    endtask

    initial begin
        logic [31:0] src, dst;
        int          len, waits, racc, rn;
        bit          hit;
        repeat (3) @(negedge clk);
        chk("rst.cyc", m_cyc_o, 1'b0);
        chk("rst.stb", m_stb_o, 1'b0);
        chk("rst.adr", m_adr_o, 32'h0);
        chk("rst.dat", m_dat_o, 64'h0);
        chk("rst.sel", m_sel_o, 8'h0);
        chk("rst.we", m_we_o, 1'b0);
        chk("rst.busy", busy_o, 1'b0);
        chk("rst.done", done_o, 1'b0);
        chk("rst.err", err_o, 1'b0);
        chk("rst.cti", m_cti_o, 3'b000);
        rstn = 1'b1;
        @(negedge clk);

        mem.delete();
        mem[32'h1000] = 64'hA5A5_0000_1234_5678;
        run_copy("len1", 32'h1000, 32'h2000, 1, 0, -1, 0, -1, 1'b0);
        chk("len1.mem", mem[32'h2000], 64'hA5A5_0000_1234_5678);
        chk("len1.sel", m_sel_o, 8'hFF);

        mem.delete();
        run_copy("len4w2", 32'h0, 32'h100, 4, 2, -1, 0, -1, 1'b0);

        mem.delete();
        run_copy("wrap", 32'hFFFF_FFF8, 32'h4000, 2, 0, -1, 0, -1, 1'b0);

        mem.delete();
        run_copy("rty3", 32'h3000, 32'h5000, 1, 0, 1, 3, -1, 1'b0);
        run_copy("rty15", 32'h3100, 32'h5100, 2, 1, 2, RTY_MAX, -1, 1'b0);
        run_copy("rty16", 32'h3200, 32'h5200, 1, 0, 1, RTY_MAX + 1, -1, 1'b0);

        run_copy("errack", 32'h6000, 32'h7000, 3, 0, -1, 0, 0, 1'b0);
        run_copy("after_err", 32'h6100, 32'h7100, 2, 0, -1, 0, -1, 1'b1);

        run_copy("len0", 32'h8000, 32'h9000, 0, 0, -1, 0, -1, 1'b0);

        mem.delete();
        s_waits = 3;
        s_rty_acc = -1;
        s_err_acc = -1;
        s_run++;
        src_adr_i = 32'hA000;
        dst_adr_i = 32'hB000;
        len_i = 16'd2;
        start_i = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            hit = m_cyc_o && m_we_o;
        end
        chk("rstmid.reach", m_cyc_o & m_we_o, 1'b1);
        rstn = 1'b0;
        #1;
        chk("rstmid.cyc", m_cyc_o, 1'b0);
        chk("rstmid.stb", m_stb_o, 1'b0);
        chk("rstmid.busy", busy_o, 1'b0);
        chk("rstmid.adr", m_adr_o, 32'h0);
        @(negedge clk);
        chk("rstmid.done", done_o, 1'b0);
        rstn = 1'b1;
        @(negedge clk);
        run_copy("post_rst", 32'hC000, 32'hD000, 2, 0, -1, 0, -1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            mem.delete();
            len = $urandom_range(1, 5);
            waits = $urandom_range(0, 2);
            src = $urandom & 32'hFFFF_FFF8;
            dst = $urandom & 32'hFFFF_FFF8;
            racc = $urandom_range(0, 2 * len - 1);
            rn = $urandom_range(0, 4);
            run_copy($sformatf("rnd%0d", r), src, dst, len, waits, racc, rn,
                     -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_dma_copy.md
# wb_dma_copy

Wishbone bus master that copies a block of `c_DATA_WIDTH`-bit words from a source address to a destination address, one single-word read followed by one single-word write per word. It sits upstream of the two-master Wishbone arbiter and connects to its M1 (SGDMA) master port. Every cycle it starts obeys the arbiter's rule: the address is valid one clock before `cyc`/`stb` assert, so the arbiter can register its slave-select lines.

## Interface
- `c_DATA_WIDTH`, 64, Wishbone data width in bits; the byte-address step per word is `c_DATA_WIDTH/8`.
- `c_LEN_WIDTH`, 16, width of the word-count input.
- `c_RTY_MAX`, 15, number of consecutive `rty` responses on a single access before the transfer aborts with an error.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  one-cycle pulse that launches a copy; ignored while `busy_o`=1.
- `src_adr_i`  in  32  source byte address, sampled when a start is accepted.
- `dst_adr_i`  in  32  destination byte address, sampled when a start is accepted.
- `len_i`  in  `c_LEN_WIDTH`  number of words to copy, sampled when a start is accepted.
- `busy_o`  out  1  high from the cycle after an accepted start until the cycle `done_o` pulses.
- `done_o`  out  1  one-cycle pulse when the copy finishes or aborts.
- `err_o`  out  1  sticky abort flag; cleared by the next accepted start.
- `m_adr_o`  out  32  Wishbone address.
- `m_dat_o`  out  `c_DATA_WIDTH`  Wishbone write data.
- `m_dat_i`  in  `c_DATA_WIDTH`  Wishbone read data.
- `m_sel_o`  out  `c_DATA_WIDTH/8`  byte selects.
- `m_we_o`  out  1  write enable.
- `m_cyc_o`  out  1  Wishbone cycle.
- `m_stb_o`  out  1  Wishbone strobe.
- `m_cti_o`  out  3  cycle type; always 3'b000 (classic).
- `m_ack_i`  in  1  slave acknowledge.
- `m_err_i`  in  1  slave error.
- `m_rty_i`  in  1  slave retry.

## Operation
- All outputs are registered. Reset values: all outputs 0, including `m_adr_o`, `m_dat_o` and `m_sel_o`.
- Internal state: `src_ptr`, `dst_ptr`, `remaining`, `rty_cnt`, and the data register `rd_data`.
- **IDLE**
  - On `start_i`: latch the address and length inputs, clear `err_o`.
  - If `len_i`=0: go to DONE.
  - Otherwise: go to RD_SETUP.
- **RD_SETUP** (exactly one cycle)
  - Drive `m_adr_o`=`src_ptr`, `m_we_o`=0, `m_sel_o`=all ones, `m_cyc_o`=`m_stb_o`=0.
  - Go to RD_CYC.
- **RD_CYC**
  - Drive `m_cyc_o`=`m_stb_o`=1, with the address held.
  - Response priority per cycle is err > ack > rty.
  - `m_err_i`: drop `cyc`/`stb`, set `err_o`, go to DONE.
  - `m_ack_i`: capture `m_dat_i` into `rd_data`, clear `rty_cnt`, drop `cyc`/`stb`, go to WR_SETUP.
  - `m_rty_i`: drop `cyc`/`stb`, increment `rty_cnt`.
    - If the incremented count exceeds `c_RTY_MAX`: set `err_o`, go to DONE.
    - Otherwise: go back to RD_SETUP.
  - No response: stay in RD_CYC. There is no timeout.
- **WR_SETUP** (exactly one cycle)
  - Drive `m_adr_o`=`dst_ptr`, `m_dat_o`=`rd_data`, `m_we_o`=1, `cyc`/`stb`=0.
- **WR_CYC**
  - Response handling is the same as RD_CYC.
  - A retry returns to WR_SETUP.
  - On ack:
    - add `c_DATA_WIDTH/8` to both `src_ptr` and `dst_ptr`, modulo 2^32 (wrap from 32'hFFFFFFF8 to 0 is legal);
    - decrement `remaining`;
    - if `remaining` was 1: go to DONE; otherwise go to RD_SETUP.
- **DONE**
  - Pulse `done_o` and deassert `busy_o` in this cycle, then go to IDLE.
- `m_cyc_o` always drops for at least one cycle between accesses. This lets the arbiter hand the bus to M0 between words.
- `m_adr_o`, `m_dat_o` and `m_we_o` hold their last values in IDLE.
- Reset asserted mid-operation: all outputs go to 0 immediately and the state returns to IDLE. No done pulse is produced.

## Timing
- The address and `m_we_o` are stable for one cycle with `cyc`=0 before `cyc`/`stb` rise, and stay stable until the ack cycle.
- With a zero-wait slave (ack in the first `stb` cycle), each word takes 4 cycles: RD_SETUP, RD_CYC, WR_SETUP, WR_CYC.
- An N-word copy with zero-wait slaves:
  - start accepted at cycle 0;
  - `busy_o`=1 from cycle 1 to cycle 4N;
  - `done_o` pulses at cycle 4N+1, and `busy_o` is 0 in that cycle.
- `len_i`=0: `done_o` pulses 2 cycles after the start, and there is no bus activity.
- Each wait state adds one cycle. Each retry adds 2 cycles (setup + strobe).
- `start_i` in the same cycle as `done_o` is ignored; a new start is accepted only in IDLE.

## Test plan
- `len`=1, src=0x1000, dst=0x2000, zero-wait slave where 0x1000 holds 0xA5A5_0000_1234_5678 -> one read at 0x1000 and one write at 0x2000 with that data; `done_o` at cycle 5; `err_o`=0.
- `len`=4, src=0x0, dst=0x100, slave adds 2 wait states per access -> addresses step by 8, the 4 words are copied in order, `done_o` at cycle 4·4+4·4+1=33.
- `len`=2, src=0xFFFFFFF8 -> the second read is at 0x00000000; the copy completes without error.
- Slave asserts `rty` 3 times on the first write, then ack -> 3 extra setup/strobe pairs, the data is correct, `err_o`=0. A separate run asserts `rty` 16 times -> abort with `err_o`=1 and `done_o` pulsed.
- `err` and `ack` asserted together on a read -> abort, no write issued, `err_o`=1; the next start clears `err_o`.
- Every access checks the address is stable for 1 cycle with `cyc`=0 before `cyc` rises. `rstn` pulled low during WR_CYC -> `m_cyc_o`/`m_stb_o` are 0 at once; the next start runs a clean copy.
